// File: rtl/ifu_fetch_fsm.sv
// ifu_fetch_fsm
// Instruction-fetch controller on the producer side of the IFU->IDU handshake.
// It issues one read per instruction on an address/data memory channel,
// captures the returned word, presents {pc, inst} to the IDU until accepted,
// and then waits for the core's commit and next PC before it fetches again.
// Exactly one instruction is in flight at any time.
//
// All handshake outputs are registers that are updated together with the
// state. Their values therefore depend only on registered state, and there
// is no combinational path from any ready input to a valid output.

module ifu_fetch_fsm #(
    parameter logic [31:0] PC_RESET = 32'h8000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    // Memory read channel: address phase
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,

    // Memory read channel: data phase
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,

    // IFU -> IDU handshake
    output logic              valid_post_o,
    input  logic              ready_post_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,

    // Commit feedback from the core
    input  logic              commit_i,
    input  logic [ADDR_W-1:0] next_pc_i,

    // Sticky fetch error flag
    output logic              fetch_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AREQ    = 3'd1,
        ST_RDATA   = 3'd2,
        ST_SEND    = 3'd3,
        ST_WCOMMIT = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_inst;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_valid_post;
    logic                r_fetch_err;

    // Qualified handshake events. Each one is masked by its own output, so
    // a ready or valid that arrives in any other state is ignored.
    logic                w_ar_fire;
    logic                w_r_fire;
    logic                w_post_fire;
    logic                w_commit;

    assign w_ar_fire   = r_arvalid    && arready_i;
    assign w_r_fire    = r_rready     && rvalid_i;
    assign w_post_fire = r_valid_post && ready_post_i;
    assign w_commit    = (r_state == ST_WCOMMIT) && commit_i;

    // Fetch sequencer: next state, registered handshake outputs, PC and instruction.
    // NOTE: every register here uses non-blocking assignment. All of them then
    // update together at the edge and see the same pre-edge values, which is
    // what keeps the outputs aligned with the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= PC_RESET[ADDR_W-1:0];
            r_inst       <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_valid_post <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            case (r_state)
                // One idle cycle after reset, then start the first fetch.
                ST_IDLE: begin
                    r_state   <= ST_AREQ;
                    r_arvalid <= 1'b1;
                end

                // The address is r_pc and does not change while the request is
                // pending. An rvalid in this same cycle is not consumed here,
                // because rready stays low until RDATA.
                ST_AREQ: begin
                    if (w_ar_fire) begin
                        r_state   <= ST_RDATA;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end

                // Wait for the read data. An error response parks the FSM in ERR.
                ST_RDATA: begin
                    if (w_r_fire) begin
                        r_rready <= 1'b0;
                        if (rresp_i == RESP_OKAY) begin
                            r_inst       <= rdata_i;
                            r_state      <= ST_SEND;
                            r_valid_post <= 1'b1;
                        end else begin
                            r_fetch_err  <= 1'b1;
                            r_state      <= ST_ERR;
                        end
                    end
                end

                // Hold valid, pc and inst until the IDU accepts the instruction.
                ST_SEND: begin
                    if (w_post_fire) begin
                        r_state      <= ST_WCOMMIT;
                        r_valid_post <= 1'b0;
                    end
                end

                // The next fetch address comes from the core when it commits.
                // It is used unchanged; alignment is the core's concern.
                ST_WCOMMIT: begin
                    if (w_commit) begin
                        r_pc      <= next_pc_i;
                        r_state   <= ST_AREQ;
                        r_arvalid <= 1'b1;
                    end
                end

                // Dead end until reset. All handshake outputs were already
                // cleared on the way in.
                ST_ERR: begin
                    r_state <= ST_ERR;
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_arvalid    <= 1'b0;
                    r_rready     <= 1'b0;
                    r_valid_post <= 1'b0;
                end
            endcase
        end
    end

    assign araddr_o     = r_pc;
    assign arvalid_o    = r_arvalid;
    assign rready_o     = r_rready;
    assign valid_post_o = r_valid_post;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign fetch_err_o  = r_fetch_err;

    // Handshake stability: a pending request or presentation must not be withdrawn or altered.
    a_ar_stable : assert property (@(posedge clk) disable iff (rst)
        (arvalid_o && !arready_i) |=> (arvalid_o && $stable(araddr_o)));

    a_post_stable : assert property (@(posedge clk) disable iff (rst)
        (valid_post_o && !ready_post_i) |=> (valid_post_o && $stable(pc_o) && $stable(inst_o)));

    a_onehot_hs : assert property (@(posedge clk) disable iff (rst)
        $onehot0({arvalid_o, rready_o, valid_post_o}));

endmodule

// File: tb/tb_ifu_fetch_fsm.sv
// tb_ifu_fetch_fsm
// Bench for ifu_fetch_fsm. A table of per-instruction scenarios drives the
// memory and IDU sides with chosen wait states. Each table entry holds the
// stimulus and the PC that the fetch must use. An accepted read pushes the
// expected {pc, inst} onto a scoreboard, and the entry is popped when the IDU
// transfer takes place. Hand-written sequences cover the error response and
// a reset in the middle of a fetch.

module tb_ifu_fetch_fsm;

    localparam logic [31:0] PC_RESET = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic        valid_post_o;
    logic        ready_post_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        commit_i;
    logic [31:0] next_pc_i;
    logic        fetch_err_o;

    ifu_fetch_fsm #(
        .PC_RESET (PC_RESET),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .valid_post_o (valid_post_o),
        .ready_post_i (ready_post_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .commit_i     (commit_i),
        .next_pc_i    (next_pc_i),
        .fetch_err_o  (fetch_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One fetch scenario: the stimulus plus the PC that the fetch must use.
    typedef struct {
        int          ar_dly;          // cycles arready_i stays low in AREQ
        int          r_dly;           // cycles rvalid_i stays low in RDATA
        int          idu_dly;         // cycles ready_post_i stays low in SEND
        int          cm_dly;          // cycles before commit_i in WCOMMIT
        bit          noise;           // drive out-of-state handshake inputs
        bit          commit_in_send;  // stray commit pulse during SEND
        logic [31:0] rdata;
        logic [31:0] next_pc;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[7];
    int   n_checks;
    int   n_errors;
    int   n_xfers;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        arready_i    = 1'b0;
        rdata_i      = '0;
        rresp_i      = 2'b00;
        rvalid_i     = 1'b0;
        ready_post_i = 1'b0;
        commit_i     = 1'b0;
        next_pc_i    = '0;
    endtask

    // Hold reset for one edge, check the reset state, then release reset so
    // that the DUT goes through IDLE and is in AREQ at return.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_arvalid",  32'(arvalid_o),    32'd0);
        check("rst_rready",   32'(rready_o),     32'd0);
        check("rst_valid",    32'(valid_post_o), 32'd0);
        check("rst_err",      32'(fetch_err_o),  32'd0);
        check("rst_pc",       pc_o,              PC_RESET);
        check("rst_inst",     inst_o,            32'd0);
        rst = 1'b0;
        tick();
        check("idle_to_areq", 32'(arvalid_o),    32'd1);
    endtask

    // Run one full fetch transaction. The DUT must be in AREQ on entry and is
    // back in AREQ at v.next_pc on return.
    task automatic run_vec(input vec_t v, input int idx);
        sb_t e;
        // AREQ: the request stays up with a fixed address until arready_i
        for (int c = 0; c <= v.ar_dly; c++) begin
            check("areq_arvalid", 32'(arvalid_o),    32'd1);
            check("areq_araddr",  araddr_o,          v.exp_pc);
            check("areq_rready",  32'(rready_o),     32'd0);
            check("areq_valid",   32'(valid_post_o), 32'd0);
            arready_i = (c == v.ar_dly);
            rvalid_i  = v.noise;
            rdata_i   = 32'hBAD0_0000 + 32'(idx);
            rresp_i   = 2'b00;
            tick();
        end
        arready_i = 1'b0;
        rvalid_i  = 1'b0;
        // RDATA: rready_o stays high until rvalid_i
        for (int c = 0; c <= v.r_dly; c++) begin
            check("rdata_rready",  32'(rready_o),     32'd1);
            check("rdata_arvalid", 32'(arvalid_o),    32'd0);
            check("rdata_valid",   32'(valid_post_o), 32'd0);
            arready_i = v.noise;
            if (c == v.r_dly) begin
                rvalid_i = 1'b1;
                rdata_i  = v.rdata;
                rresp_i  = 2'b00;
                e.pc     = v.exp_pc;
                e.inst   = v.rdata;
                sb.push_back(e);
            end
            tick();
        end
        rvalid_i  = 1'b0;
        arready_i = 1'b0;
        rdata_i   = 32'hBAD1_0000 + 32'(idx);
        // SEND: valid, pc and inst stay fixed until ready_post_i
        for (int c = 0; c <= v.idu_dly; c++) begin
            check("send_valid",  32'(valid_post_o), 32'd1);
            check("send_rready", 32'(rready_o),     32'd0);
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_underflow: no expected entry while valid_post_o is high");
            end else begin
                check("send_pc",   pc_o,   sb[0].pc);
                check("send_inst", inst_o, sb[0].inst);
            end
            ready_post_i = (c == v.idu_dly);
            commit_i     = v.commit_in_send && (c == 0) && (v.idu_dly > 0);
            next_pc_i    = 32'hDEAD_0000;
            rvalid_i     = v.noise;
            if (c == v.idu_dly && sb.size() != 0) begin
                void'(sb.pop_front());
                n_xfers++;
            end
            tick();
        end
        ready_post_i = 1'b0;
        commit_i     = 1'b0;
        rvalid_i     = 1'b0;
        // WCOMMIT: wait for commit_i, then take next_pc_i
        for (int c = 0; c <= v.cm_dly; c++) begin
            check("wcm_valid",   32'(valid_post_o), 32'd0);
            check("wcm_arvalid", 32'(arvalid_o),    32'd0);
            check("wcm_pc",      pc_o,              v.exp_pc);
            ready_post_i = v.noise;
            arready_i    = v.noise;
            commit_i     = (c == v.cm_dly);
            next_pc_i    = v.next_pc;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_xfers  = 0;
        //          ar r idu cm noise cis rdata          next_pc        exp_pc
        vecs[0] = '{0, 0, 0, 0, 1'b0, 1'b0, 32'h0000_0093, 32'h8000_0010, 32'h8000_0000};
        vecs[1] = '{0, 0, 5, 1, 1'b0, 1'b1, 32'h0010_0113, 32'h8000_0014, 32'h8000_0010};
        vecs[2] = '{3, 4, 1, 0, 1'b1, 1'b0, 32'h0020_8193, 32'h8000_0102, 32'h8000_0014};
        vecs[3] = '{1, 0, 0, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h8000_0102};
        vecs[4] = '{0, 2, 2, 0, 1'b1, 1'b1, 32'h1234_5678, 32'h0000_1000, 32'h0000_0000};
        vecs[5] = '{0, 0, 0, 0, 1'b0, 1'b0, 32'h0000_0513, 32'h8000_0004, 32'h8000_0000};
        vecs[6] = '{1, 1, 1, 0, 1'b0, 1'b0, 32'h00A0_0593, 32'h8000_0008, 32'h8000_0000};

        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        do_reset();

        // Table-driven fetches: zero-wait, stalled IDU, slow memory, noise
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // Error response: sticky flag, no presentation, stuck until reset
        check("err_araddr", araddr_o, 32'h0000_1000);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check("err_rready", 32'(rready_o), 32'd1);
        rvalid_i = 1'b1;
        rresp_i  = 2'b10;
        rdata_i  = 32'hFFFF_FFFF;
        tick();
        for (int c = 0; c < 4; c++) begin
            check("err_flag",    32'(fetch_err_o),  32'd1);
            check("err_valid",   32'(valid_post_o), 32'd0);
            check("err_arvalid", 32'(arvalid_o),    32'd0);
            check("err_rready",  32'(rready_o),     32'd0);
            check("err_pc",      pc_o,              32'h0000_1000);
            arready_i    = 1'b1;
            rvalid_i     = 1'b1;
            rresp_i      = 2'b00;
            ready_post_i = 1'b1;
            commit_i     = 1'b1;
            next_pc_i    = 32'h0000_2000;
            tick();
        end
        idle_inputs();
        do_reset();
        run_vec(vecs[5], 5);

        // Reset during RDATA; the late response must be ignored
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        check("mid_rready_before", 32'(rready_o), 32'd1);
        rst = 1'b1;
        tick();
        rvalid_i = 1'b1;
        rdata_i  = 32'hCAFE_F00D;
        rst      = 1'b0;
        check("mid_rready_idle",  32'(rready_o),  32'd0);
        check("mid_arvalid_idle", 32'(arvalid_o), 32'd0);
        check("mid_pc_idle",      pc_o,           PC_RESET);
        tick();
        check("mid_rready_areq", 32'(rready_o),     32'd0);
        check("mid_arvalid",     32'(arvalid_o),    32'd1);
        check("mid_araddr",      araddr_o,          PC_RESET);
        check("mid_inst",        inst_o,            32'd0);
        check("mid_valid",       32'(valid_post_o), 32'd0);
        rvalid_i = 1'b0;
        run_vec(vecs[6], 6);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("xfer_count", 32'(n_xfers),   32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
